// File: rtl/mult_pkg.sv
// Shared defaults, tag type and requester ids for the multiplier sharing scheduler.
package mult_pkg;

  localparam int unsigned DefDataSize  = 8;
  localparam int unsigned DefLatency   = 3;
  localparam int unsigned DefFifoDepth = 4;
  localparam int unsigned DefProdWidth = 2 * DefDataSize;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // One in-flight slot of the tag pipeline.
  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

endpackage

// File: rtl/mult_result_fifo.sv
// First-word-fall-through result FIFO with an occupancy count.
// The head word reads as zero while the FIFO is empty.
module mult_result_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_pop;
  logic             full;

  // Pointers wrap modulo DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign valid_o = (count_q != '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_pop  = pop_i && valid_o;
  assign count_o = count_q;
  assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;

  // Next occupancy: simultaneous push and pop leave it unchanged.
  always_comb begin
    count_d = count_q;
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Pointer and count state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // Storage array; contents are qualified by count_q so no reset is needed.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Upstream credit accounting must make this unreachable.
  push_when_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full));

endmodule

// File: rtl/mult_share_scheduler.sv
// Shares one fixed-latency multiplier datapath between two requesters.
// Round-robin arbitration, credit-limited issue, a tag pipeline that tracks
// in-flight owners, and a result FIFO that absorbs consumer backpressure.
module mult_share_scheduler
  import mult_pkg::*;
#(
  parameter int unsigned DATA_SIZE  = DefDataSize,
  parameter int unsigned LATENCY    = DefLatency,   // >= 1
  parameter int unsigned FIFO_DEPTH = DefFifoDepth  // >= 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,

  input  logic                   req0_valid_i,
  output logic                   req0_ready_o,
  input  logic [DATA_SIZE-1:0]   req0_a_i,
  input  logic [DATA_SIZE-1:0]   req0_b_i,
  input  logic                   req0_signed_i,

  input  logic                   req1_valid_i,
  output logic                   req1_ready_o,
  input  logic [DATA_SIZE-1:0]   req1_a_i,
  input  logic [DATA_SIZE-1:0]   req1_b_i,
  input  logic                   req1_signed_i,

  output logic                   dp_issue_o,
  output logic [DATA_SIZE-1:0]   dp_a_o,
  output logic [DATA_SIZE-1:0]   dp_b_o,
  output logic                   dp_signed_o,
  input  logic [2*DATA_SIZE-1:0] dp_product_i,

  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [2*DATA_SIZE-1:0] res_product_o,
  output logic                   res_id_o
);

  localparam int unsigned PROD_W = 2 * DATA_SIZE;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  logic                active_q;
  logic                last_grant_q;
  tag_t [LATENCY-1:0]  tag_q;
  logic [CNT_W-1:0]    inflight_q, inflight_d;
  logic [CNT_W-1:0]    fifo_cnt;
  logic [CNT_W:0]      credit_sum;
  logic                can_issue;
  logic                grant;
  logic                grant_id;
  logic                tag_exit;
  logic                exit_id;
  logic [PROD_W:0]     head;

  // Credits cover every result that may still land in the FIFO. Registered
  // counts only, so a pop frees its slot for issue one cycle later.
  assign credit_sum = {1'b0, inflight_q} + {1'b0, fifo_cnt};
  assign can_issue  = active_q && (credit_sum < (CNT_W + 1)'(FIFO_DEPTH));

  // Round-robin arbiter: on conflict the requester not granted last wins.
  always_comb begin
    grant    = 1'b0;
    grant_id = REQ0;
    if (can_issue) begin
      if (req0_valid_i && req1_valid_i) begin
        grant    = 1'b1;
        grant_id = ~last_grant_q;
      end else if (req0_valid_i) begin
        grant    = 1'b1;
        grant_id = REQ0;
      end else if (req1_valid_i) begin
        grant    = 1'b1;
        grant_id = REQ1;
      end
    end
  end

  // Handshake and operand muxes; operands are forced to zero when idle.
  always_comb begin
    req0_ready_o = grant && (grant_id == REQ0);
    req1_ready_o = grant && (grant_id == REQ1);
    dp_issue_o   = grant;
    dp_a_o       = '0;
    dp_b_o       = '0;
    dp_signed_o  = 1'b0;
    if (grant) begin
      dp_a_o      = (grant_id == REQ1) ? req1_a_i      : req0_a_i;
      dp_b_o      = (grant_id == REQ1) ? req1_b_i      : req0_b_i;
      dp_signed_o = (grant_id == REQ1) ? req1_signed_i : req0_signed_i;
    end
  end

  // active_q holds issue off while reset is asserted and drops it
  // asynchronously, so ready/dp outputs read zero during reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q     <= 1'b0;
      last_grant_q <= REQ1;
    end else begin
      active_q <= 1'b1;
      if (grant) last_grant_q <= grant_id;
    end
  end

  // Tag pipeline: the last stage lines up with dp_product_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= '{valid: grant, id: grant_id};
      for (int i = 1; i < int'(LATENCY); i++) begin
        tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign tag_exit = tag_q[LATENCY-1].valid;
  assign exit_id  = tag_q[LATENCY-1].id;

  // In-flight count: issue and exit in the same cycle cancel.
  always_comb begin
    inflight_d = inflight_q;
    case ({grant, tag_exit})
      2'b10:   inflight_d = inflight_q + CNT_W'(1);
      2'b01:   inflight_d = inflight_q - CNT_W'(1);
      default: ;
    endcase
  end

  // In-flight count register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) inflight_q <= '0;
    else         inflight_q <= inflight_d;
  end

  mult_result_fifo #(
    .WIDTH (PROD_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (tag_exit),
    .push_data_i ({exit_id, dp_product_i}),
    .pop_i       (res_ready_i),
    .valid_o     (res_valid_o),
    .data_o      (head),
    .count_o     (fifo_cnt)
  );

  assign res_id_o      = head[PROD_W];
  assign res_product_o = head[PROD_W-1:0];

  one_ready_max: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(req0_ready_o && req1_ready_o));

  inflight_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight_q <= CNT_W'(LATENCY));

endmodule

// File: tb/tb_mult_share_scheduler.sv
// Directed bench for mult_share_scheduler with a behavioural 3-cycle datapath.
module tb_mult_share_scheduler;

  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req0_signed;
  logic [7:0]  req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_signed;
  logic [7:0]  req1_a, req1_b;
  logic        dp_issue, dp_signed;
  logic [7:0]  dp_a, dp_b;
  logic [15:0] dp_product;
  logic        res_valid, res_ready, res_id;
  logic [15:0] res_product;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  logic [16:0] sb [$];
  logic [15:0] exp_p0, exp_p1;
  logic        auto_inc = 1'b0;
  logic        exp_id;
  int unsigned n_iss, n_acc, n_ops;
  logic        saw1;
  logic [3:0]  pat;

  always #5 clk = ~clk;

  mult_share_scheduler dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .req0_valid_i  (req0_valid),
    .req0_ready_o  (req0_ready),
    .req0_a_i      (req0_a),
    .req0_b_i      (req0_b),
    .req0_signed_i (req0_signed),
    .req1_valid_i  (req1_valid),
    .req1_ready_o  (req1_ready),
    .req1_a_i      (req1_a),
    .req1_b_i      (req1_b),
    .req1_signed_i (req1_signed),
    .dp_issue_o    (dp_issue),
    .dp_a_o        (dp_a),
    .dp_b_o        (dp_b),
    .dp_signed_o   (dp_signed),
    .dp_product_i  (dp_product),
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .res_product_o (res_product),
    .res_id_o      (res_id)
  );

  // Behavioural datapath: product appears LAT cycles after the issue edge.
  logic [15:0] dp_pipe [LAT];

  function automatic logic [15:0] mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    logic signed [15:0] sa, sb2;
    if (s) begin
      sa  = {{8{a[7]}}, a};
      sb2 = {{8{b[7]}}, b};
      return sa * sb2;
    end
    return {8'h00, a} * {8'h00, b};
  endfunction

  always @(posedge clk) begin
    dp_pipe[0] <= dp_issue ? mul(dp_a, dp_b, dp_signed) : 16'hDEAD;
    for (int i = 1; i < int'(LAT); i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign dp_product = dp_pipe[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
  endtask

  // Called mid-cycle: score this cycle, advance one edge, land 1ns after it.
  task automatic adv();
    logic [16:0] e;
    logic        acc0;
    check("ready_onehot", req0_ready & req1_ready, 0);
    check("issue_vs_ready", dp_issue, req0_ready | req1_ready);
    if (dp_issue) sb.push_back({req1_ready, req1_ready ? exp_p1 : exp_p0});
    if (res_valid && res_ready) begin
      if (sb.size() == 0) begin
        check("pop_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        check("pop_id", res_id, e[16]);
        check("pop_prod", res_product, e[15:0]);
      end
    end
    acc0 = req0_ready;
    @(posedge clk);
    #1;
    if (auto_inc && acc0) begin
      req0_a = req0_a + 8'd1;
      exp_p0 = {8'h00, req0_a};
    end
  endtask

  task automatic drain(input int unsigned cycles);
    for (int k = 0; k < int'(cycles); k++) begin
      #1;
      adv();
    end
  endtask

  initial begin
    req0_valid = 1'b1; req0_a = 8'd13; req0_b = 8'd11; req0_signed = 1'b0;
    req1_valid = 1'b0; req1_a = 8'd0;  req1_b = 8'd0;  req1_signed = 1'b0;
    res_ready = 1'b0;
    exp_p0 = 16'h0; exp_p1 = 16'h0;

    // Reset: outputs zero even with a pending request.
    repeat (2) @(posedge clk);
    #2;
    check("rst_ready0", req0_ready, 0);
    check("rst_issue", dp_issue, 0);
    check("rst_dp_a", dp_a, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_prod", res_product, 0);
    check("rst_res_id", res_id, 0);
    rst_n = 1'b1;
    req0_valid = 1'b0;
    @(posedge clk);
    #1;

    // Single unsigned op: 13*11 = 143.
    req0_valid = 1'b1; exp_p0 = 16'd143;
    #1;
    check("t1_ready0", req0_ready, 1);
    check("t1_ready1", req1_ready, 0);
    check("t1_issue", dp_issue, 1);
    check("t1_dp_a", dp_a, 8'd13);
    check("t1_dp_b", dp_b, 8'd11);
    adv();
    req0_valid = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      check("t1_no_res_yet", res_valid, 0);
      adv();
    end
    #1;
    check("t1_res_valid", res_valid, 1);
    check("t1_res_prod", res_product, 16'd143);
    check("t1_res_id", res_id, 0);
    res_ready = 1'b1;
    adv();

    // Both valid, consumer ready: grants alternate, starting with req1.
    req0_valid = 1'b1; req0_a = 8'hFE; req0_b = 8'd5; req0_signed = 1'b1; exp_p0 = 16'hFFF6;
    req1_valid = 1'b1; req1_a = 8'd3;  req1_b = 8'd7; req1_signed = 1'b0; exp_p1 = 16'h0015;
    exp_id = 1'b1;
    n_iss = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (c < 4) check("t2_back_to_back", dp_issue, 1);
      if (dp_issue) begin
        check("t2_grant_id", req1_ready, exp_id);
        check("t2_dp_a", dp_a, exp_id ? 8'h03 : 8'hFE);
        check("t2_dp_signed", dp_signed, exp_id ? 1'b0 : 1'b1);
        exp_id = ~exp_id;
        n_iss++;
      end
      adv();
    end
    check("t2_issue_count", n_iss >= 8, 1);
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(8);
    check("t2_drained", sb.size(), 0);

    // Consumer stalled: exactly FIFO_DEPTH accepts, then ready stays low.
    res_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (req0_ready || req1_ready) n_acc++;
      adv();
    end
    check("t3_accepts", n_acc, 4);
    #1;
    check("t3_ready_low", req0_ready | req1_ready, 0);
    check("t3_res_valid", res_valid, 1);
    res_ready = 1'b1;
    adv();
    #1;
    check("t3_reissue_after_pop", dp_issue, 1);
    check("t3_pop1_valid", res_valid, 1);
    adv();
    req0_valid = 1'b0; req1_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("t3_pop_stream", res_valid, 1);
      adv();
    end
    drain(8);
    check("t3_drained", sb.size(), 0);

    // Streaming with a ready consumer: FIFO holds at most one, pointers wrap.
    auto_inc = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h40; req0_b = 8'd1; req0_signed = 1'b0; exp_p0 = 16'h0040;
    n_ops = 0; saw1 = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (req0_ready) n_ops++;
      if (dut.fifo_cnt == 1) saw1 = 1'b1;
      check("t4_fifo_cnt_le1", dut.fifo_cnt <= 1, 1);
      adv();
    end
    req0_valid = 1'b0;
    drain(8);
    auto_inc = 1'b0;
    check("t4_ops", n_ops >= 10, 1);
    check("t4_saw_one", saw1, 1);
    check("t4_drained", sb.size(), 0);

    // Reset with two in flight and two buffered.
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 8'd9; req0_b = 8'd9; req0_signed = 1'b0; exp_p0 = 16'h0051;
    for (int c = 0; c < 5; c++) begin
      #1;
      adv();
    end
    req0_valid = 1'b0;
    #1;
    check("t5_inflight", dut.inflight_q, 2);
    check("t5_fifo_cnt", dut.fifo_cnt, 2);
    check("t5_pre_valid", res_valid, 1);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check("t5_rst_res_valid", res_valid, 0);
    check("t5_rst_res_prod", res_product, 0);
    check("t5_rst_res_id", res_id, 0);
    check("t5_rst_issue", dp_issue, 0);
    check("t5_rst_ready0", req0_ready, 0);
    check("t5_rst_dp_a", dp_a, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      check("t5_no_stale", res_valid, 0);
      adv();
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    req1_a = 8'd2; req1_b = 8'd2; req1_signed = 1'b0; exp_p1 = 16'h0004;
    #1;
    check("t5_first_conflict_r0", req0_ready, 1);
    check("t5_first_conflict_r1", req1_ready, 0);
    adv();
    #1;
    check("t5_second_conflict_r1", req1_ready, 1);
    adv();
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(8);
    check("t5_drained", sb.size(), 0);

    // Idle gaps on one requester (1,0,1,1): operands zero when not issuing.
    req0_a = 8'h21; req0_b = 8'h02; req0_signed = 1'b1; exp_p0 = 16'h0042;
    pat = 4'b1101;
    for (int c = 0; c < 8; c++) begin
      req0_valid = pat[c % 4];
      #1;
      if (req0_valid) begin
        check("t6_issue", dp_issue, 1);
        check("t6_dp_a", dp_a, 8'h21);
      end else begin
        check("t6_idle_issue", dp_issue, 0);
        check("t6_idle_a", dp_a, 0);
        check("t6_idle_b", dp_b, 0);
        check("t6_idle_signed", dp_signed, 0);
      end
      check("t6_inflight_le3", dut.inflight_q <= 3, 1);
      adv();
    end
    req0_valid = 1'b0;
    drain(8);
    check("t6_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
